// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, req/ack memory handshake, skid buffer, stall and branch redirect
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   stall_enable          downstream stall; OUT is not consumed while high
//   BRANCH_TAKEN/TARGET   single-cycle redirect pulse and its target (low bits ignored)
//   IMEM_REQ/ADDR         registered word request to instruction memory
//   IMEM_ACK/DATA         memory response, valid only while IMEM_REQ is high
//   INSTR_OUT/COUNTER_OUT fetched instruction and its address, zero when bubble
//   FETCH_VALID           INSTR_OUT/COUNTER_OUT carry a real instruction
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall_enable,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] INSTR_OUT,
    output logic [31:0] COUNTER_OUT,
    output logic        FETCH_VALID
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
    state_t      state;
    logic [31:0] pc, pc_inc, target, skid_instr, skid_pc, rdr;
    logic        ack_ok, loadable;
    // ACK only counts against an outstanding request
    assign ack_ok   = IMEM_REQ && IMEM_ACK;
    assign loadable = !FETCH_VALID || !stall_enable;
    assign pc_inc   = pc + 32'd4;
    assign target   = {BRANCH_TARGET[31:2], 2'b00};
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            IMEM_REQ    <= 1'b0;
            IMEM_ADDR   <= RESET_PC;
            INSTR_OUT   <= 32'h0;
            COUNTER_OUT <= 32'h0;
            FETCH_VALID <= 1'b0;
            skid_instr  <= 32'h0;
            skid_pc     <= 32'h0;
            rdr         <= 32'h0;
        end else if (BRANCH_TAKEN) begin
            FETCH_VALID <= 1'b0;
            INSTR_OUT   <= 32'h0;
            COUNTER_OUT <= 32'h0;
            case (state)
                FETCH: begin
                    // a pending request cannot be abandoned, so wait it out in DRAIN
                    if (ack_ok || !IMEM_REQ) begin
                        pc        <= target;
                        IMEM_REQ  <= 1'b1;
                        IMEM_ADDR <= target;
                    end else begin
                        rdr   <= target;
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    pc        <= target;
                    IMEM_REQ  <= 1'b1;
                    IMEM_ADDR <= target;
                    state     <= FETCH;
                end
                default: begin
                    rdr <= target;
                    if (ack_ok) begin
                        pc        <= target;
                        IMEM_ADDR <= target;
                        state     <= FETCH;
                    end
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    IMEM_REQ <= 1'b1;
                    if (ack_ok) begin
                        pc        <= pc_inc;
                        IMEM_ADDR <= pc_inc;
                        if (loadable) begin
                            FETCH_VALID <= 1'b1;
                            INSTR_OUT   <= IMEM_DATA;
                            COUNTER_OUT <= pc;
                        end else begin
                            skid_instr <= IMEM_DATA;
                            skid_pc    <= pc;
                            IMEM_REQ   <= 1'b0;
                            state      <= HOLD;
                        end
                    end else begin
                        IMEM_ADDR <= pc;
                        // consumed with nothing to replace it: present a bubble
                        if (!stall_enable) begin
                            FETCH_VALID <= 1'b0;
                            INSTR_OUT   <= 32'h0;
                            COUNTER_OUT <= 32'h0;
                        end
                    end
                end
                HOLD: begin
                    // the request is reissued on the same edge the skid drains, so streaming has no gap
                    if (loadable) begin
                        FETCH_VALID <= 1'b1;
                        INSTR_OUT   <= skid_instr;
                        COUNTER_OUT <= skid_pc;
                        IMEM_REQ    <= 1'b1;
                        IMEM_ADDR   <= pc;
                        state       <= FETCH;
                    end
                end
                default: begin
                    if (ack_ok) begin
                        pc        <= rdr;
                        IMEM_ADDR <= rdr;
                        state     <= FETCH;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage streaming, stall, branch, drain, wrap and reset
module tb_fetch_stage;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        stall_enable = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'h0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_DATA;
    logic [31:0] INSTR_OUT;
    logic [31:0] COUNTER_OUT;
    logic        FETCH_VALID;
    int          vectors = 0;
    int          miscompares = 0;

    fetch_stage dut (
        .CLK(CLK), .RESET(RESET), .stall_enable(stall_enable),
        .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
        .IMEM_DATA(IMEM_DATA), .INSTR_OUT(INSTR_OUT), .COUNTER_OUT(COUNTER_OUT),
        .FETCH_VALID(FETCH_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hE1A0_0000;
    endfunction

    assign IMEM_DATA = mem(IMEM_ADDR);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic out_is(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'h0, FETCH_VALID}, {31'h0, v});
        chk({tag, ".pc"}, COUNTER_OUT, v ? pc : 32'h0);
        chk({tag, ".instr"}, INSTR_OUT, v ? mem(pc) : 32'h0);
    endtask

    task automatic req_is(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'h0, IMEM_REQ}, {31'h0, r});
        chk({tag, ".addr"}, IMEM_ADDR, a);
    endtask

    initial begin
        @(negedge CLK);
        req_is("rst", 1'b0, 32'h0);
        out_is("rst", 1'b0, 32'h0);
        RESET = 1'b0;
        IMEM_ACK = 1'b1;
        step();
        req_is("first_req", 1'b1, 32'h0);
        out_is("first_req", 1'b0, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            out_is("stream", 1'b1, 32'(i * 4));
            step();
        end
        out_is("pre_stall", 1'b1, 32'h10);
        stall_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            out_is("stall_hold", 1'b1, 32'h10);
            chk("stall_noreq", {31'h0, IMEM_REQ}, 32'h0);
        end
        stall_enable = 1'b0;
        step();
        out_is("resume0", 1'b1, 32'h14);
        req_is("resume0", 1'b1, 32'h18);
        step();
        out_is("resume1", 1'b1, 32'h18);
        step();
        out_is("resume2", 1'b1, 32'h1C);
        stall_enable = 1'b1;
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h43;
        step();
        out_is("br_ack_stall", 1'b0, 32'h0);
        req_is("br_ack_stall", 1'b1, 32'h40);
        BRANCH_TAKEN = 1'b0;
        stall_enable = 1'b0;
        IMEM_ACK = 1'b0;
        step();
        req_is("wait40", 1'b1, 32'h40);
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h200;
        step();
        BRANCH_TAKEN = 1'b0;
        req_is("drain0", 1'b1, 32'h40);
        out_is("drain0", 1'b0, 32'h0);
        step();
        req_is("drain1", 1'b1, 32'h40);
        out_is("drain1", 1'b0, 32'h0);
        IMEM_ACK = 1'b1;
        step();
        req_is("redir200", 1'b1, 32'h200);
        out_is("redir200", 1'b0, 32'h0);
        step();
        out_is("got200", 1'b1, 32'h200);
        IMEM_ACK = 1'b0;
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h100;
        step();
        out_is("dd0", 1'b0, 32'h0);
        req_is("dd0", 1'b1, 32'h204);
        BRANCH_TARGET = 32'h300;
        step();
        BRANCH_TAKEN = 1'b0;
        IMEM_ACK = 1'b1;
        step();
        req_is("dd_redir", 1'b1, 32'h300);
        step();
        out_is("got300", 1'b1, 32'h300);
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFF;
        step();
        BRANCH_TAKEN = 1'b0;
        req_is("wrap_req", 1'b1, 32'hFFFF_FFFC);
        step();
        out_is("wrap_top", 1'b1, 32'hFFFF_FFFC);
        req_is("wrap_next", 1'b1, 32'h0);
        step();
        out_is("wrap_zero", 1'b1, 32'h0);
        stall_enable = 1'b1;
        IMEM_ACK = 1'b0;
        step();
        out_is("pre_rst", 1'b1, 32'h0);
        #2 RESET = 1'b1;
        #1;
        req_is("async_rst", 1'b0, 32'h0);
        out_is("async_rst", 1'b0, 32'h0);
        stall_enable = 1'b0;
        IMEM_ACK = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        step();
        req_is("stale_ack", 1'b1, 32'h0);
        out_is("stale_ack", 1'b0, 32'h0);
        step();
        out_is("refetch", 1'b1, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined ARM processor; sits directly upstream of the IF/ID pipeline register. Maintains the program counter and issues word requests to instruction memory over a req/ack handshake. Presents each fetched instruction with its own address through a registered output plus a one-entry skid buffer. Honours the hazard-unit stall and flushes and redirects on a taken branch.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- stall_enable  in  1  downstream stall (same signal that freezes IF/ID); output not consumed while high
- BRANCH_TAKEN  in  1  taken-branch redirect, single-cycle pulse
- BRANCH_TARGET  in  32  redirect address; bits [1:0] ignored (treated as 0)
- IMEM_REQ  out  1  instruction memory request, registered
- IMEM_ADDR  out  32  request address, registered, word aligned
- IMEM_ACK  in  1  memory response valid; IMEM_DATA sampled this cycle
- IMEM_DATA  in  32  instruction word for current IMEM_ADDR
- INSTR_OUT  out  32  fetched instruction to IF/ID; 32'h0 when bubble
- COUNTER_OUT  out  32  address of INSTR_OUT; 32'h0 when bubble
- FETCH_VALID  out  1  INSTR_OUT/COUNTER_OUT hold a real instruction

## Operation
- Reset is asserted with RESET (asynchronous, active-high) on clock CLK.
- State: PC, output register OUT (valid, instr, pc), skid register SKID (instr, pc), redirect register RDR, FSM {FETCH, HOLD, DRAIN}.
- Consume rule: OUT is consumed on any edge with FETCH_VALID=1 and stall_enable=0. OUT may load on an edge when it is invalid or consumed on that edge.
- Request rule: while IMEM_REQ=1, IMEM_ADDR stays stable until the IMEM_ACK cycle. A request is never abandoned.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC.
  - On ACK with OUT loadable: OUT<={1,IMEM_DATA,PC}, PC<=PC+4, stay FETCH.
  - On ACK with OUT not loadable: SKID<={IMEM_DATA,PC}, PC<=PC+4, go HOLD.
- HOLD: IMEM_REQ=0. When OUT is loadable: OUT<=SKID, go FETCH.
- DRAIN: IMEM_REQ=1 with the old IMEM_ADDR. On ACK: discard data, PC<=RDR, go FETCH.
- BRANCH_TAKEN has priority over stall_enable and ACK. On that edge OUT.valid<=0 and INSTR_OUT/COUNTER_OUT<=0. Then, by state:
  - FETCH, ACK high: drop data, PC<=target, stay FETCH.
  - FETCH, no ACK: RDR<=target, go DRAIN.
  - HOLD: SKID discarded, PC<=target, go FETCH.
  - DRAIN: RDR<=target (latest branch wins). If ACK is also high: PC<=target, go FETCH.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. Target is masked to {BRANCH_TARGET[31:2],2'b00}.

## Timing
- Reset values: IMEM_REQ=0, IMEM_ADDR=RESET_PC, INSTR_OUT=0, COUNTER_OUT=0, FETCH_VALID=0. PC=RESET_PC; FSM=FETCH; SKID, RDR=0.
- First edge after reset release drives IMEM_REQ=1, IMEM_ADDR=RESET_PC.
- Latency: ACK at edge n puts the instruction on INSTR_OUT after edge n.
- Zero-wait memory (ACK tied high) with no stall: one instruction per cycle; COUNTER_OUT increments by 4 each cycle.
- Stall of k cycles: OUT holds. At most one extra instruction is buffered (SKID), and no request is issued in HOLD. Streaming resumes with no lost or duplicated instruction.
- Branch: target request is on IMEM_ADDR one edge after BRANCH_TAKEN (FETCH with ACK, or HOLD), or one edge after the draining ACK (DRAIN).
- Reset mid-request: everything returns to reset values immediately. A later stale ACK, arriving while IMEM_REQ=0, is ignored.
- ACK while IMEM_REQ=0 is ignored in all states.

## Test plan
- Reset then ACK tied high, no stall: INSTR_OUT sequence equals mem[0],mem[4],mem[8]…, COUNTER_OUT 0,4,8…, FETCH_VALID=1 from second post-reset edge.
- Stall 3 cycles starting with OUT=@0x10, ACK high: OUT holds @0x10, SKID=@0x14, IMEM_REQ=0 in HOLD. After release, OUT is @0x14 then @0x18; no gap, no repeat.
- ACK with 2-cycle wait, BRANCH_TAKEN to 0x200 while request @0x40 pending: IMEM_ADDR stays 0x40 until ACK, data dropped, next IMEM_ADDR=0x200, FETCH_VALID=0 until @0x200 arrives.
- BRANCH_TAKEN coincident with ACK and stall_enable: OUT flushed to 0/0/valid 0, acked word dropped, next IMEM_ADDR=target.
- Two branches during DRAIN (0x100 then 0x300): fetch resumes at 0x300 only.
- PC at 0xFFFF_FFFC with zero-wait memory: next COUNTER_OUT=0. RESET pulsed mid-wait: outputs 0 asynchronously, and refetch starts at RESET_PC.
